// File: rtl/rf_bypass_pkg.sv
// rf_bypass_pkg: shared register-file sizing (width, register count, address width, zero-register index)
package rf_bypass_pkg;
  localparam int RF_WIDTH    = 16;
  localparam int RF_NREGS    = 16;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_ZERO_IDX = 0;
  typedef logic [RF_WIDTH-1:0] rf_word_t;
endpackage

// File: rtl/rf_reg.sv
// rf_reg: WIDTH-bit enabled register with async clear; ports clk rst en d -> q (holds q when en=0)
module rf_reg
  import rf_bypass_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else     q <= en ? d : q;
endmodule

// File: rtl/rf_bypass.sv
// rf_bypass: 2R1W register file with same-cycle WB->ID bypass; ports clk rst we waddr wdata raddr1 raddr2 -> rdata1 rdata2
module rf_bypass
  import rf_bypass_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int NREGS   = RF_NREGS,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2
);
  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(RF_ZERO_IDX);
  logic [NREGS-1:0] wen;
  logic [WIDTH-1:0] q [NREGS];
  logic             zero1, zero2, byp1, byp2;
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    assign wen[i] = we && waddr == ADDR_W'(i) && !(ZERO_R0 != 0 && i == RF_ZERO_IDX);
    rf_reg #(.WIDTH(WIDTH)) u_reg (
      .clk(clk),
      .rst(rst),
      .en (wen[i]),
      .d  (wdata),
      .q  (q[i])
    );
  end
  always_comb begin
    zero1  = ZERO_R0 != 0 && raddr1 == ZIDX;
    zero2  = ZERO_R0 != 0 && raddr2 == ZIDX;
    byp1   = we && waddr == raddr1 && !zero1;
    byp2   = we && waddr == raddr2 && !zero2;
    rdata1 = rst ? '0 : byp1 ? wdata : zero1 ? '0 : q[raddr1];
    rdata2 = rst ? '0 : byp2 ? wdata : zero2 ? '0 : q[raddr2];
  end
endmodule
